// File: rtl/pwm_pkg.sv
// Shared PWM constants and the capture FSM state encoding.
// The generator channel and the capture block both size their counters from PWM_CNT_W.
package pwm_pkg;

    localparam int PWM_CNT_W       = 32;
    localparam int PWM_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } cap_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronizer chain for an asynchronous level, plus a delay flop.
// Provides the synchronized level and single-cycle rise/fall strobes.
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync    <= '0;
            r_level_d <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_level_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_level_d;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_level_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input, rise to rise,
// in clk cycles, and flags a stalled input after a programmable timeout.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W,
    parameter int SYNC_STAGES = PWM_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_in,
    input  logic [CNT_W-1:0] timeout_in,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid_out,
    output logic             timeout_out,
    output logic             level_out
);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             w_level;
    logic             w_rise;
    logic             w_fall;
    logic             w_unused_fall;
    logic             w_timeout_hit;

    cap_state_e       r_state;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_stall_seen;
    logic [CNT_W-1:0] r_period_out;
    logic [CNT_W-1:0] r_high_out;
    logic             r_valid_out;
    logic             r_timeout_out;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    pwm_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_async (pwm_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Periods are measured rise to rise, so the falling strobe is not needed here.
    assign w_unused_fall = w_fall;

    // r_stall_seen keeps a static input from re-reporting the same stall every timeout.
    assign w_timeout_hit = (timeout_in != CNT_ZERO) && (r_stall_cnt >= timeout_in) && !r_stall_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_period_cnt  <= CNT_ZERO;
            r_high_cnt    <= CNT_ZERO;
            r_stall_cnt   <= CNT_ZERO;
            r_stall_seen  <= 1'b0;
            r_period_out  <= CNT_ZERO;
            r_high_out    <= CNT_ZERO;
            r_valid_out   <= 1'b0;
            r_timeout_out <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            if (!enable_in) begin
                r_state      <= ST_IDLE;
                r_period_cnt <= CNT_ZERO;
                r_high_cnt   <= CNT_ZERO;
                r_stall_cnt  <= CNT_ZERO;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state      <= ST_ARM;
                        r_period_cnt <= CNT_ZERO;
                        r_high_cnt   <= CNT_ZERO;
                        r_stall_cnt  <= CNT_ONE;
                    end
                    ST_ARM: begin
                        if (w_rise) begin
                            r_state      <= ST_MEASURE;
                            r_period_cnt <= CNT_ONE;
                            r_high_cnt   <= CNT_ONE;
                            r_stall_cnt  <= CNT_ONE;
                            r_stall_seen <= 1'b0;
                        end else begin
                            r_stall_cnt <= sat_inc(r_stall_cnt);
                            if (w_timeout_hit) begin
                                r_period_out  <= CNT_ZERO;
                                r_high_out    <= CNT_ZERO;
                                r_timeout_out <= 1'b1;
                                r_valid_out   <= 1'b1;
                                r_stall_seen  <= 1'b1;
                            end
                        end
                    end
                    ST_MEASURE: begin
                        // A rise landing on the timeout cycle completes a normal period.
                        if (w_rise) begin
                            r_period_out  <= r_period_cnt;
                            r_high_out    <= r_high_cnt;
                            r_timeout_out <= 1'b0;
                            r_valid_out   <= 1'b1;
                            r_period_cnt  <= CNT_ONE;
                            r_high_cnt    <= CNT_ONE;
                            r_stall_cnt   <= CNT_ONE;
                        end else if (w_timeout_hit) begin
                            r_period_out  <= CNT_ZERO;
                            r_high_out    <= CNT_ZERO;
                            r_timeout_out <= 1'b1;
                            r_valid_out   <= 1'b1;
                            r_stall_seen  <= 1'b1;
                            r_state       <= ST_ARM;
                            r_period_cnt  <= CNT_ZERO;
                            r_high_cnt    <= CNT_ZERO;
                            r_stall_cnt   <= CNT_ONE;
                        end else begin
                            r_period_cnt <= sat_inc(r_period_cnt);
                            r_stall_cnt  <= sat_inc(r_stall_cnt);
                            if (w_level) begin
                                r_high_cnt <= sat_inc(r_high_cnt);
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign period_out  = r_period_out;
    assign high_out    = r_high_out;
    assign valid_out   = r_valid_out;
    assign timeout_out = r_timeout_out;
    assign level_out   = w_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: a 32-bit instance and an 8-bit instance checked every cycle
// against a timestamp-based reference model of rise-to-rise measurement.
`timescale 1ns/1ps
module tb_pwm_capture;

    localparam int MAXC = 16384;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_in;
    logic [31:0] timeout_in;
    logic        pwm_in;
    logic [31:0] period_out;
    logic [31:0] high_out;
    logic        valid_out;
    logic        timeout_out;
    logic        level_out;

    logic [7:0]  timeout8;
    logic        pwm8;
    logic [7:0]  period8;
    logic [7:0]  high8;
    logic        valid8;
    logic        timeout_o8;
    logic        level8;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(32), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable_in   (enable_in),
        .timeout_in  (timeout_in),
        .pwm_in      (pwm_in),
        .period_out  (period_out),
        .high_out    (high_out),
        .valid_out   (valid_out),
        .timeout_out (timeout_out),
        .level_out   (level_out)
    );

    pwm_capture #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .enable_in   (enable_in),
        .timeout_in  (timeout8),
        .pwm_in      (pwm8),
        .period_out  (period8),
        .high_out    (high8),
        .valid_out   (valid8),
        .timeout_out (timeout_o8),
        .level_out   (level8)
    );

    int checks = 0;
    int errors = 0;

    // Reference model. lvl[u][k] is the input level sampled at clock edge k (since reset).
    // A rise sampled at edge n is reported at edge n+2; results are timestamp differences.
    bit     lvl [2][MAXC];
    int     m;
    bit     active [2];
    int     last_rise [2];
    int     anchor [2];
    bit     stalled [2];
    longint e_per [2];
    longint e_high [2];
    bit     e_to [2];
    bit     e_valid [2];
    int     ph0, ph1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input int u);
        longint mx;
        mx = (u == 0) ? 64'h0000_0000_FFFF_FFFF : 64'd255;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < MAXC; k++) lvl[u][k] = 1'b0;
            active[u] = 1'b0; last_rise[u] = -1; anchor[u] = 0; stalled[u] = 1'b0;
            e_per[u] = 0; e_high[u] = 0; e_to[u] = 1'b0; e_valid[u] = 1'b0;
        end
        m = 3;
    endtask

    task automatic model_edge(input int u, input bit en, input longint tmo);
        bit     rise;
        longint h;
        rise = lvl[u][m-2] && !lvl[u][m-3];
        e_valid[u] = 1'b0;
        if (!en) begin
            active[u] = 1'b0; last_rise[u] = -1;
        end else if (!active[u]) begin
            active[u] = 1'b1; last_rise[u] = -1; anchor[u] = m;
        end else if (rise) begin
            if (last_rise[u] >= 0) begin
                h = 0;
                for (int k = last_rise[u] - 2; k <= m - 3; k++) h += longint'(lvl[u][k]);
                e_per[u] = sat(longint'(m - last_rise[u]), u);
                e_high[u] = sat(h, u);
                e_to[u] = 1'b0;
                e_valid[u] = 1'b1;
            end
            last_rise[u] = m; anchor[u] = m; stalled[u] = 1'b0;
        end else if (tmo != 0 && !stalled[u] && sat(longint'(m - anchor[u]), u) >= tmo) begin
            e_per[u] = 0; e_high[u] = 0; e_to[u] = 1'b1; e_valid[u] = 1'b1;
            stalled[u] = 1'b1; last_rise[u] = -1; anchor[u] = m;
        end
    endtask

    // One clock: drive levels, take the edge, update the model, check all outputs.
    task automatic step(input bit a, input bit b, input bit en);
        if (m >= MAXC) begin
            $display("FAIL model_capacity: observed %0d expected below %0d", m, MAXC);
            errors++;
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "model capacity exceeded");
        end
        pwm_in = a; pwm8 = b; enable_in = en;
        lvl[0][m] = a; lvl[1][m] = b;
        @(posedge clk);
        model_edge(0, en, longint'(timeout_in));
        model_edge(1, en, longint'(timeout8));
        #1;
        chk("valid", valid_out, e_valid[0]);
        chk("period", period_out, e_per[0]);
        chk("high", high_out, e_high[0]);
        chk("timeout", timeout_out, e_to[0]);
        chk("level", level_out, lvl[0][m-1]);
        chk("valid8", valid8, e_valid[1]);
        chk("period8", period8, e_per[1]);
        chk("high8", high8, e_high[1]);
        chk("timeout8", timeout_o8, e_to[1]);
        chk("level8", level8, lvl[1][m-1]);
        m++;
    endtask

    // Periodic patterns: unit 0 period p0 with d0 high cycles, unit 1 likewise.
    task automatic run(input int p0, input int d0, input int p1, input int d1, input bit en, input int n);
        for (int i = 0; i < n; i++) begin
            step((ph0 % p0) < d0, (ph1 % p1) < d1, en);
            ph0++; ph1++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_period"}, period_out, 0);
        chk({tag, "_high"}, high_out, 0);
        chk({tag, "_valid"}, valid_out, 0);
        chk({tag, "_timeout"}, timeout_out, 0);
        chk({tag, "_level"}, level_out, 0);
        chk({tag, "_period8"}, period8, 0);
    endtask

    initial begin
        int p, d, n;
        rst = 1'b1; enable_in = 1'b0; timeout_in = 32'd0; timeout8 = 8'd0;
        pwm_in = 1'b0; pwm8 = 1'b0; ph0 = 0; ph1 = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Static-low input with timeout disabled: nothing is ever reported.
        run(1, 0, 1, 0, 1'b1, 200);
        check_all_zero("static_low");

        // Generator loopback, period 10 duty 3.
        timeout_in = 32'd50; ph0 = 0;
        run(10, 3, 1, 0, 1'b1, 100);
        chk("loop_period", period_out, 32'd10);
        chk("loop_high", high_out, 32'd3);
        chk("loop_timeout", timeout_out, 1'b0);

        // Reprogrammed to 100% duty: one final result, then a single timeout.
        run(7, 7, 1, 0, 1'b1, 80);
        chk("stall_timeout", timeout_out, 1'b1);
        chk("stall_period", period_out, 32'd0);
        chk("stall_high", high_out, 32'd0);
        chk("stall_level", level_out, 1'b1);
        run(7, 7, 1, 0, 1'b1, 60);

        // Enable dropped mid-period, then re-armed.
        ph0 = 0;
        run(9, 4, 1, 0, 1'b1, 25);
        run(9, 4, 1, 0, 1'b0, 4);
        run(9, 4, 1, 0, 1'b1, 40);
        chk("reenable_period", period_out, 32'd9);
        chk("reenable_high", high_out, 32'd4);

        // Randomized patterns and timeouts, including timeouts shorter than the period.
        for (int r = 0; r < 10; r++) begin
            p = $urandom_range(2, 40);
            d = $urandom_range(1, p - 1);
            timeout_in = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(2, 60));
            n = $urandom_range(30, 150);
            run(p, d, 1, 0, ($urandom_range(0, 7) != 0), n);
        end
        timeout_in = 32'd20;
        for (int i = 0; i < 150; i++) step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1);

        // Asynchronous reset in the middle of a measurement.
        timeout_in = 32'd0; ph0 = 0;
        run(10, 3, 1, 0, 1'b1, 35);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        ph0 = 0;
        run(10, 3, 1, 0, 1'b1, 60);
        chk("resume_period", period_out, 32'd10);
        chk("resume_high", high_out, 32'd3);

        // 8-bit instance: period 300 saturates, then high time saturates too.
        ph1 = 0;
        run(10, 3, 300, 100, 1'b1, 1000);
        chk("sat_period8", period8, 8'd255);
        chk("sat_high8", high8, 8'd100);
        run(10, 3, 300, 280, 1'b1, 1000);
        chk("sat2_period8", period8, 8'd255);
        chk("sat2_high8", high8, 8'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM capture/measurement block, the receive-side counterpart of the team's PWM generator channel. It samples an asynchronous PWM input and measures the period and high time of each complete cycle in `clk` cycles. It also detects a stalled (static) input. Results go to the command/response layer so the PC tool can read back measured frequency and duty of external PWM sources or loop back generated channels.

## Interface
Parameters:
- `CNT_W`, 32: width of period/high counters and result registers.
- `SYNC_STAGES`, 2: input synchronizer depth, minimum 2.

Ports:
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `enable_in` in 1: capture enable, level-sensitive.
- `timeout_in` in CNT_W: stall timeout in clk cycles; 0 disables timeout detection.
- `pwm_in` in 1: asynchronous PWM input.
- `period_out` out CNT_W: last measured period in clk cycles. Reset value 0.
- `high_out` out CNT_W: last measured high time in clk cycles. Reset value 0.
- `valid_out` out 1: one-cycle pulse when `period_out`/`high_out`/`timeout_out` update. Reset value 0.
- `timeout_out` out 1: input stalled. Reset value 0.
- `level_out` out 1: synchronized input level, reported for the static case. Reset value 0.

## Operation
- Input path:
  - `SYNC_STAGES` flops give synchronized level `s`.
  - One delay flop gives `s_d`.
  - `rise = s & ~s_d`, `fall = ~s & s_d`.
  - `level_out = s`.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE: counters held at 0. Exit to ARM when `enable_in=1`.
  - ARM: discards the partial first cycle. On `rise`: `period_cnt<=1`, `high_cnt<=1`, go to MEASURE. No result is produced.
  - MEASURE, on `rise`:
    - latch `period_out<=period_cnt` and `high_out<=high_cnt`;
    - `timeout_out<=0`, pulse `valid_out`;
    - `period_cnt<=1`, `high_cnt<=1`.
  - MEASURE, otherwise:
    - `period_cnt++`;
    - `high_cnt++` only while `s=1`.
  - Timeout applies in ARM and MEASURE. When `timeout_in!=0` and the cycles since the last `rise` (or since entering ARM) reach `timeout_in`:
    - `period_out<=0`, `high_out<=0`, `timeout_out<=1`, pulse `valid_out`;
    - go to ARM.
  - After a timeout, no further `valid_out` fires while the input stays static.
- Any state with `enable_in=0`:
  - go to IDLE and clear counters;
  - `period_out`, `high_out`, `timeout_out` hold their values;
  - `valid_out` is 0.
- Arithmetic:
  - counters saturate at all-ones and never wrap;
  - a saturated period is reported as all-ones;
  - comparison is `stall_cnt >= timeout_in`, unsigned.
- Simultaneous events:
  - `rise` in the same cycle the timeout is reached: `rise` wins and a normal measurement is reported.
  - `enable_in` falling in the same cycle as `rise`: disable wins and no result is produced.
- Input semantics:
  - glitches shorter than one clk may be missed; no filtering is required.
  - 100% duty (no fall) or 0% duty (no rise) is reported only via timeout, with `level_out` giving the static level.

## Timing
- Latency:
  - `pwm_in` edge sampled at clk edge k gives `s` valid after edge k+SYNC_STAGES-1.
  - Results and the `valid_out` pulse are registered at edge k+SYNC_STAGES, i.e. 2 cycles after sampling for the default.
- Throughput: one result per input period. Minimum measurable period is 2 clk cycles, with high and low each at least 1 cycle.
- `valid_out` is high for exactly one cycle per update. Outputs are stable between pulses. No handshake or backpressure: the consumer samples on `valid_out`.
- Reset mid-operation:
  - all outputs and state go to the reset values immediately;
  - after release, the first `valid_out` fires no earlier than the second sampled rising edge.

## Structure
- Shared package `pwm_pkg`: `CNT_W` default, FSM state encoding (IDLE/ARM/MEASURE), shared with the generator channel's width constant.
- One sub-module `pwm_sync_edge`: synchronizer chain, delay flop, and `rise`/`fall`/`level` outputs. It is reusable by other capture inputs.
- FSM, counters and result registers live in `pwm_capture`.

## Test plan
- Loopback from the team's PWM generator channel (period 10, duty 3, enabled) → after the second rising edge, `valid_out` pulses every 10 cycles with `period_out=10`, `high_out=3`, `timeout_out=0`.
- Generator reprogrammed mid-run to period 7, duty 7 (100%) with `timeout_in=50` → one final valid result, then `timeout_out=1`, `period_out=0`, `high_out=0`, `level_out=1` within 50 cycles of the last rise. No further valid pulses.
- Static-low input with `timeout_in=0` → no `valid_out` ever; outputs remain at reset values.
- Input period 2^CNT_W+5, or reduced-width build `CNT_W=8` with period 300 → `period_out=255` (saturated); no wrap artifacts.
- `enable_in` dropped between rises, then re-asserted → no result for the interrupted cycle. The first new result arrives after two fresh rises; stale outputs held until then.
- `rst` asserted asynchronously mid-MEASURE → all outputs 0 without waiting for a clock edge; correct measurement resumes after release.
